// File: rtl/stoch_decode_pkg.sv
// Shared definitions for the stochastic decode block: the FSM state encoding
// and the library-wide default window size.
package stoch_decode_pkg;

    // Default log2 window length used across the stochastic library
    localparam int DEFAULT_WINDOW_BITS = 8;

    // FSM states, encoded in two bits
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/stoch_decode_window_counter.sv
// Sample counter for one decode window. It counts enabled samples, can be
// cleared at the start of a window, and flags the last sample of the window.
module stoch_decode_window_counter #(
    parameter int WINDOW_BITS = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   clr,
    input  logic                   inc,
    output logic [WINDOW_BITS-1:0] cnt,
    output logic                   tc
);

    // Count enabled samples. Clear has priority over increment. The count
    // wraps to zero on the final sample; the FSM leaves ACCUM on that same
    // edge, so the wrapped value is never used.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + WINDOW_BITS'(1);
        end
    end

    // The terminal count marks the last sample slot of the window
    assign tc = (cnt == {WINDOW_BITS{1'b1}});

endmodule

// File: rtl/stoch_decode.sv
// Stochastic-to-binary decoder. It counts the ones in a unipolar bitstream
// over a window of 2^WINDOW_BITS enabled samples and then presents the count
// on a valid/ready output.
module stoch_decode
    import stoch_decode_pkg::*;
#(
    parameter int WINDOW_BITS = DEFAULT_WINDOW_BITS,
    parameter int OUT_WIDTH   = WINDOW_BITS + 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 en,
    input  logic                 x,
    output logic                 busy,
    output logic [OUT_WIDTH-1:0] value,
    output logic                 value_valid,
    input  logic                 value_ready
);

    state_t                 state;
    logic [OUT_WIDTH-1:0]   ones_cnt;
    logic [OUT_WIDTH-1:0]   ones_next;
    logic [WINDOW_BITS-1:0] samp_cnt;
    logic                   samp_last;
    logic                   samp_clr;
    logic                   samp_inc;
    logic                   handshake;

    // Window sample counter, cleared whenever a new window is launched
    stoch_decode_window_counter #(
        .WINDOW_BITS(WINDOW_BITS)
    ) u_window_counter (
        .CLK (CLK),
        .RST (RST),
        .clr (samp_clr),
        .inc (samp_inc),
        .cnt (samp_cnt),
        .tc  (samp_last)
    );

    // Launch, sample and handshake qualifiers derived from the state register.
    // A new window starts from IDLE, or straight out of HOLD when the result
    // is accepted on the same edge that start is requested.
    assign handshake = (state == ST_HOLD) && value_valid && value_ready;
    assign samp_clr  = start && ((state == ST_IDLE) || handshake);
    assign samp_inc  = (state == ST_ACCUM) && en;
    assign ones_next = ones_cnt + OUT_WIDTH'(x);
    assign busy      = (state == ST_ACCUM);

    // Control FSM with the ones counter and the registered result. Reset
    // overrides everything and discards any partial window.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            ones_cnt    <= '0;
            value       <= '0;
            value_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_ACCUM;
                        ones_cnt <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (en) begin
                        ones_cnt <= ones_next;
                        if (samp_last) begin
                            value       <= ones_next;
                            value_valid <= 1'b1;
                            state       <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (handshake) begin
                        value_valid <= 1'b0;
                        if (start) begin
                            state    <= ST_ACCUM;
                            ones_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    value_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/stoch_decode.md
Name: stoch_decode

Overview:
- Downstream consumer of stochastic arithmetic stages, such as the stochastic adder.
- Converts a unipolar stochastic bitstream back to a binary magnitude by counting ones over a fixed window of 2^WINDOW_BITS enabled samples.
- Presents the result on a valid/ready output handshake.
- Sits at the boundary between the stochastic datapath and binary logic: readout, debug capture, feedback into bitstream generators.

Parameters:
- WINDOW_BITS, 8, log2 of window length; window = 2^WINDOW_BITS enabled samples.
- OUT_WIDTH, WINDOW_BITS+1, width of result; must hold the full count 2^WINDOW_BITS.

Ports:
- CLK  input  1  clock; one clock for the whole block.
- RST  input  1  reset; one clock; reset is synchronous and active-high.
- start  input  1  request a new decode window; honoured only in IDLE, or in HOLD on the same cycle as the output handshake.
- en  input  1  sample qualifier; x is counted only on cycles with en=1 in ACCUM.
- x  input  1  stochastic bitstream bit.
- busy  output  1  high in ACCUM.
- value  output  OUT_WIDTH  number of ones in the completed window.
- value_valid  output  1  result available; held until accepted.
- value_ready  input  1  consumer accepts value.

Behaviour:
- Reset:
  - RST=1 at a rising edge forces state=IDLE; ones count, sample count and value go to 0; value_valid=0, busy=0.
  - Reset has priority over every other input, including mid-window and mid-HOLD; a partial window is discarded.
- States: IDLE, ACCUM, HOLD, registered and encoded in 2 bits.
- IDLE:
  - start=1 at an edge: -> ACCUM, ones_cnt<=0, samp_cnt<=0.
  - otherwise stay.
- ACCUM:
  - At each edge with en=1: ones_cnt<=ones_cnt+x, samp_cnt<=samp_cnt+1.
  - en=0: counters hold; no sample is taken.
  - Final sample is the edge where en=1 and samp_cnt==2^WINDOW_BITS-1. At that edge: value<=ones_cnt+x, value_valid<=1, state->HOLD.
  - start is ignored in ACCUM.
- HOLD:
  - value and value_valid are held stable while value_ready=0.
  - Handshake is the edge with value_valid=1 and value_ready=1. At that edge:
    - start=1: -> ACCUM with counters cleared (back-to-back, no idle cycle); value_valid<=0.
    - start=0: -> IDLE; value_valid<=0.
  - value keeps its last result after handshake until the next window completes.
- Latency: value_valid rises at the edge taking the 2^WINDOW_BITS-th enabled sample. With en tied high this is 2^WINDOW_BITS+1 edges after the start edge, counting the start edge itself.
- Width rules:
  - samp_cnt is WINDOW_BITS wide and wraps to 0 on the final sample; the wrap is don't-care because the state leaves ACCUM.
  - ones_cnt is OUT_WIDTH wide and never overflows: max 2^WINDOW_BITS.
  - All arithmetic is unsigned.
- busy = (state==ACCUM), driven combinationally from the state register.
- x and en carry no assumption beyond synchronous timing to CLK; no internal synchronisers.

Decomposition:
- Shared stochastic package/header (stoch_defs.vh) holds:
  - state encoding localparams: ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_HOLD=2'd2;
  - the default WINDOW_BITS for the library.
- One natural sub-module: stoch_window_counter, a WINDOW_BITS counter with clear, enable and a terminal-count flag. The FSM and ones counter stay in stoch_decode.

Test Plan (WINDOW_BITS=4, window=16):
- All ones: RST pulse, start for 1 cycle, en=1, x=1 for 16 cycles -> value_valid rises on the 16th sample edge; value=16; busy low thereafter.
- Alternating and all zeros: x=1010... -> value=8; all zeros -> value=0.
- Stalls: en high only on every third cycle, x=1 on exactly 5 enabled samples -> value=5 after 16 enabled samples (48 cycles); start pulses during ACCUM have no effect.
- Backpressure and back-to-back:
  - Hold value_ready=0 for 10 cycles -> value/value_valid stable.
  - Then value_ready=1 with start=1 -> next edge busy=1, value_valid=0.
  - Second window with 12 ones -> value=12.
- Reset mid-operation:
  - Assert RST after 7 samples -> IDLE, value=0, value_valid=0.
  - New window with 3 ones -> value=3; no residue from the aborted window.
